output_port_bank: RTL and testbench
===================================

# output_port_bank

Multi-channel, buffered successor to the single 8-bit output port register. Stores the value written by an OUT instruction, taken from the ID/EX stage, in one of NUM_PORTS per-port FIFOs. Each port drains to external logic over a valid/ready handshake. When the addressed FIFO is full, the block raises a stall to the pipeline instead of dropping data.

## Interface
Parameters:
- DATA_W, 8: width of one output word.
- NUM_PORTS, 4: number of output channels; must be ≥ 2.
- DEPTH, 4: entries per port FIFO; must be a power of 2 and ≥ 2.

Ports (SEL_W = clog2(NUM_PORTS), CNT_W = clog2(DEPTH+1)):
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- wr_en, input, 1: OUT instruction in ID/EX requests a write.
- wr_port, input, SEL_W: destination port index.
- wr_data, input, DATA_W: forwarded operand to write.
- wr_stall, output, 1: combinational; wr_en is high and FIFO[wr_port] is full. The pipeline holds ID/EX while this is high.
- out_data, output, NUM_PORTS*DATA_W: port p occupies bits [p*DATA_W +: DATA_W]; carries the FIFO head.
- out_valid, output, NUM_PORTS: bit p is high when FIFO p is non-empty.
- out_ready, input, NUM_PORTS: bit p is high when the consumer accepts port p.
- port_full, output, NUM_PORTS: bit p is high when FIFO p holds DEPTH entries.

## Operation
- Each port has its own circular buffer with read pointer, write pointer and a CNT_W count.
  - Pointers are clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Write acceptance: wr_en && count[wr_port] < DEPTH.
  - On acceptance, wr_data goes into slot wptr[wr_port], wptr increments, and count increments.
  - Only one port is written per cycle.
- Write rejection: wr_en && count[wr_port] == DEPTH.
  - wr_stall = 1, no state change.
  - A pop on the same port in the same cycle does not unblock the write. There is no full-FIFO pass-through; the write retries next cycle.
- Pop on port p: out_valid[p] && out_ready[p]. On a pop, rptr[p] increments and count[p] decrements.
  - All ports may pop in the same cycle.
  - out_ready on an empty port is ignored.
- Simultaneous accepted write and pop on the same port: count is unchanged and both pointers advance. This is legal at any fill level except full-with-write, which is rejected as above.
- out_data for port p equals mem[p][rptr[p]] when out_valid[p] = 1, and all-zeros when the port is empty.
- wr_port ≥ NUM_PORTS (non-power-of-2 NUM_PORTS only): the write is ignored, wr_stall = 0.
- Reset (any time, including mid-transfer):
  - All pointers and counts clear to 0.
  - out_valid = 0, out_data = 0, port_full = 0, wr_stall = 0 (with wr_en low).
  - FIFO storage contents need not be cleared.

## Timing
- Write-to-visible latency is 1 cycle. For a write accepted at edge N, out_valid and out_data update right after edge N.
- A pop at edge N exposes the next entry, or out_valid = 0, right after edge N.
- out_valid, out_data and port_full are functions of registered state only; no combinational path from out_ready or wr_*.
- wr_stall is combinational from wr_en, wr_port and registered count; no path from out_ready.
- Sustained throughput is one write per cycle in total and one pop per cycle per port.
- Reset deassertion is synchronous to clk externally; the first write is accepted on the first edge after rst falls.

## Test plan
- Reset: assert rst mid-stream with port 0 holding 2 entries → out_valid = 0, out_data = 0, port_full = 0 immediately, without waiting for a clock edge.
- Single write: wr_en = 1, wr_port = 2, wr_data = 0xA5 for one cycle, out_ready = 0 → next cycle out_valid = 4'b0100 and out_data[23:16] = 0xA5. Then out_ready[2] = 1 for one cycle → out_valid[2] = 0.
- Fill and stall: 4 writes to port 1 (0x11..0x14) with out_ready = 0 → port_full[1] = 1. A 5th write of 0x15 → wr_stall = 1 while held. Pop once → 0x15 is accepted the following cycle. Drain order is 0x12, 0x13, 0x14, 0x15.
- Full-with-pop: port 3 full, wr_en to port 3 and out_ready[3] = 1 in the same cycle → wr_stall = 1, one entry popped, write accepted the next cycle.
- Wrap-around: 10 write/pop pairs on port 0 with out_ready[0] held at 1, data 0x00..0x09 → all values emerge in order, count never exceeds 1, no stall.
- Concurrency: write to port 0 while ports 1 and 2 pop simultaneously → per-port counts are independent, no cross-port corruption.

Source files
------------

// File: rtl/output_port_bank_if.sv
// Write/drain bundle for output_port_bank: the pipeline write port plus the per-port
// valid/ready drain channels, flattened as NUM_PORTS lanes of DATA_W.
interface output_port_bank_if #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned NUM_PORTS = 4
);
    localparam int unsigned SEL_W = $clog2(NUM_PORTS);

    logic                        wr_en;
    logic [SEL_W-1:0]            wr_port;
    logic [DATA_W-1:0]           wr_data;
    logic                        wr_stall;
    logic [NUM_PORTS*DATA_W-1:0] out_data;
    logic [NUM_PORTS-1:0]        out_valid;
    logic [NUM_PORTS-1:0]        out_ready;
    logic [NUM_PORTS-1:0]        port_full;

    modport master (
        output wr_en, wr_port, wr_data, out_ready,
        input  wr_stall, out_data, out_valid, port_full
    );

    modport slave (
        input  wr_en, wr_port, wr_data, out_ready,
        output wr_stall, out_data, out_valid, port_full
    );
endinterface

// File: rtl/output_port_bank.sv
// Bank of NUM_PORTS circular FIFOs fed by OUT instructions from ID/EX; each port drains over
// valid/ready and a write to a full port stalls the pipeline instead of dropping data.
module output_port_bank #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned DEPTH     = 4
) (
    input logic               clk,
    input logic               rst,
    output_port_bank_if.slave bus
);
    localparam int unsigned SEL_W = $clog2(NUM_PORTS);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0]    r_mem  [NUM_PORTS][DEPTH];
    logic [PTR_W-1:0]     r_rptr [NUM_PORTS];
    logic [PTR_W-1:0]     r_wptr [NUM_PORTS];
    logic [CNT_W-1:0]     r_cnt  [NUM_PORTS];

    logic [NUM_PORTS-1:0] w_valid;
    logic [NUM_PORTS-1:0] w_full;
    logic [NUM_PORTS-1:0] w_pop;
    logic [NUM_PORTS-1:0] w_push;
    logic                 w_port_ok;

    // Only matters for non-power-of-2 NUM_PORTS: out-of-range writes are dropped silently.
    assign w_port_ok = 32'(bus.wr_port) < NUM_PORTS;

    always_comb begin
        w_valid        = '0;
        w_full         = '0;
        w_pop          = '0;
        w_push         = '0;
        bus.out_data   = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            w_valid[p] = r_cnt[p] != '0;
            w_full[p]  = r_cnt[p] == CNT_W'(DEPTH);
            w_pop[p]   = w_valid[p] && bus.out_ready[p];
            // A pop in the same cycle does not free room for a write to a full port.
            w_push[p]  = bus.wr_en && w_port_ok && (bus.wr_port == SEL_W'(p)) && !w_full[p];
            if (w_valid[p]) begin
                bus.out_data[p*DATA_W +: DATA_W] = r_mem[p][r_rptr[p]];
            end
        end
    end

    assign bus.wr_stall  = bus.wr_en && w_port_ok && w_full[bus.wr_port];
    assign bus.out_valid = w_valid;
    assign bus.port_full = w_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                r_rptr[p] <= '0;
                r_wptr[p] <= '0;
                r_cnt[p]  <= '0;
            end
        end else begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (w_push[p]) begin
                    r_wptr[p] <= r_wptr[p] + PTR_W'(1);
                end
                if (w_pop[p]) begin
                    r_rptr[p] <= r_rptr[p] + PTR_W'(1);
                end
                if (w_push[p] && !w_pop[p]) begin
                    r_cnt[p] <= r_cnt[p] + CNT_W'(1);
                end else if (!w_push[p] && w_pop[p]) begin
                    r_cnt[p] <= r_cnt[p] - CNT_W'(1);
                end
            end
        end
    end

    // Storage is not reset; out_data is masked by out_valid.
    always_ff @(posedge clk) begin
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (w_push[p]) begin
                r_mem[p][r_wptr[p]] <= bus.wr_data;
            end
        end
    end
endmodule

// File: tb/tb_output_port_bank.sv
// Directed, table-driven bench for output_port_bank (4 ports x 4 deep x 8 bits).
module tb_output_port_bank;
    logic clk = 1'b0;
    logic rst = 1'b1;

    output_port_bank_if #(.DATA_W(8), .NUM_PORTS(4)) bus ();

    output_port_bank #(.DATA_W(8), .NUM_PORTS(4), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [1:0]  port;
        logic [7:0]  data;
        logic [3:0]  rdy;
        logic        exp_stall;
        logic [3:0]  exp_valid;
        logic [3:0]  exp_full;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input logic en, input logic [1:0] port, input logic [7:0] data,
                       input logic [3:0] rdy, input logic st, input logic [3:0] v,
                       input logic [3:0] f, input logic [31:0] od);
        vec_t e;
        e.en = en; e.port = port; e.data = data; e.rdy = rdy;
        e.exp_stall = st; e.exp_valid = v; e.exp_full = f; e.exp_data = od;
        vecs.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Stall is checked before the edge; registered outputs just after it.
    task automatic apply(input vec_t e, input string tag);
        bus.wr_en     = e.en;
        bus.wr_port   = e.port;
        bus.wr_data   = e.data;
        bus.out_ready = e.rdy;
        #1;
        chk({tag, " stall"}, 32'(bus.wr_stall), 32'(e.exp_stall));
        @(posedge clk);
        #1;
        chk({tag, " valid"}, 32'(bus.out_valid), 32'(e.exp_valid));
        chk({tag, " full"},  32'(bus.port_full), 32'(e.exp_full));
        chk({tag, " data"},  bus.out_data, e.exp_data);
    endtask

    vec_t tmp;

    initial begin
        bus.wr_en = 0; bus.wr_port = '0; bus.wr_data = '0; bus.out_ready = '0;

        // Single write to port 2, then pop
        add(1, 2, 8'hA5, 4'b0000, 0, 4'b0100, 4'b0000, 32'h00A5_0000);
        add(0, 0, 8'h00, 4'b0100, 0, 4'b0000, 4'b0000, 32'h0000_0000);
        // Fill port 1, stall while held, pop doesn't unblock in the same cycle
        add(1, 1, 8'h11, 4'b0000, 0, 4'b0010, 4'b0000, 32'h0000_1100);
        add(1, 1, 8'h12, 4'b0000, 0, 4'b0010, 4'b0000, 32'h0000_1100);
        add(1, 1, 8'h13, 4'b0000, 0, 4'b0010, 4'b0000, 32'h0000_1100);
        add(1, 1, 8'h14, 4'b0000, 0, 4'b0010, 4'b0010, 32'h0000_1100);
        add(1, 1, 8'h15, 4'b0000, 1, 4'b0010, 4'b0010, 32'h0000_1100);
        add(1, 1, 8'h15, 4'b0000, 1, 4'b0010, 4'b0010, 32'h0000_1100);
        add(1, 1, 8'h15, 4'b0010, 1, 4'b0010, 4'b0000, 32'h0000_1200);
        add(1, 1, 8'h15, 4'b0000, 0, 4'b0010, 4'b0010, 32'h0000_1200);
        add(0, 0, 8'h00, 4'b0010, 0, 4'b0010, 4'b0000, 32'h0000_1300);
        add(0, 0, 8'h00, 4'b0010, 0, 4'b0010, 4'b0000, 32'h0000_1400);
        add(0, 0, 8'h00, 4'b0010, 0, 4'b0010, 4'b0000, 32'h0000_1500);
        add(0, 0, 8'h00, 4'b0010, 0, 4'b0000, 4'b0000, 32'h0000_0000);
        // Port 3 full, write plus pop in the same cycle
        add(1, 3, 8'h31, 4'b0000, 0, 4'b1000, 4'b0000, 32'h3100_0000);
        add(1, 3, 8'h32, 4'b0000, 0, 4'b1000, 4'b0000, 32'h3100_0000);
        add(1, 3, 8'h33, 4'b0000, 0, 4'b1000, 4'b0000, 32'h3100_0000);
        add(1, 3, 8'h34, 4'b0000, 0, 4'b1000, 4'b1000, 32'h3100_0000);
        add(1, 3, 8'h35, 4'b1000, 1, 4'b1000, 4'b0000, 32'h3200_0000);
        add(1, 3, 8'h35, 4'b0000, 0, 4'b1000, 4'b1000, 32'h3200_0000);
        add(0, 0, 8'h00, 4'b1000, 0, 4'b1000, 4'b0000, 32'h3300_0000);
        add(0, 0, 8'h00, 4'b1000, 0, 4'b1000, 4'b0000, 32'h3400_0000);
        add(0, 0, 8'h00, 4'b1000, 0, 4'b1000, 4'b0000, 32'h3500_0000);
        add(0, 0, 8'h00, 4'b1000, 0, 4'b0000, 4'b0000, 32'h0000_0000);
        // Wrap-around on port 0: write/pop pairs, occupancy stays at 1
        for (int i = 0; i < 10; i++) begin
            add(1, 0, 8'(i), 4'b0001, 0, 4'b0001, 4'b0000, 32'(i));
        end
        add(0, 0, 8'h00, 4'b0001, 0, 4'b0000, 4'b0000, 32'h0000_0000);
        // Concurrency: write port 0 while ports 1 and 2 pop
        add(1, 1, 8'hAA, 4'b0000, 0, 4'b0010, 4'b0000, 32'h0000_AA00);
        add(1, 1, 8'hAB, 4'b0000, 0, 4'b0010, 4'b0000, 32'h0000_AA00);
        add(1, 2, 8'hBA, 4'b0000, 0, 4'b0110, 4'b0000, 32'h00BA_AA00);
        add(1, 2, 8'hBB, 4'b0000, 0, 4'b0110, 4'b0000, 32'h00BA_AA00);
        add(1, 0, 8'hC0, 4'b0110, 0, 4'b0111, 4'b0000, 32'h00BB_ABC0);
        add(0, 0, 8'h00, 4'b0110, 0, 4'b0001, 4'b0000, 32'h0000_00C0);
        add(0, 0, 8'h00, 4'b0001, 0, 4'b0000, 4'b0000, 32'h0000_0000);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset valid", 32'(bus.out_valid), 32'h0);
        chk("reset full",  32'(bus.port_full), 32'h0);
        chk("reset data",  bus.out_data, 32'h0);
        chk("reset stall", 32'(bus.wr_stall), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Asynchronous reset mid-stream: port 0 holds 2 entries, port 3 full
        for (int i = 0; i < 2; i++) begin
            tmp.en = 1; tmp.port = 0; tmp.data = 8'h60 + 8'(i); tmp.rdy = 0; tmp.exp_stall = 0;
            tmp.exp_valid = 4'b0001; tmp.exp_full = 0; tmp.exp_data = 32'h60;
            apply(tmp, $sformatf("pre_rst%0d", i));
        end
        for (int i = 0; i < 4; i++) begin
            tmp.en = 1; tmp.port = 3; tmp.data = 8'h70 + 8'(i); tmp.rdy = 0; tmp.exp_stall = 0;
            tmp.exp_valid = 4'b1001; tmp.exp_full = (i == 3) ? 4'b1000 : 4'b0000;
            tmp.exp_data = 32'h7000_0060;
            apply(tmp, $sformatf("pre_full%0d", i));
        end
        bus.wr_en = 0; bus.out_ready = '0;
        #2;
        rst = 1'b1;
        #1;
        chk("async rst valid", 32'(bus.out_valid), 32'h0);
        chk("async rst full",  32'(bus.port_full), 32'h0);
        chk("async rst data",  bus.out_data, 32'h0);
        chk("async rst stall", 32'(bus.wr_stall), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // First edge after reset release accepts a write
        tmp.en = 1; tmp.port = 0; tmp.data = 8'h77; tmp.rdy = 0; tmp.exp_stall = 0;
        tmp.exp_valid = 4'b0001; tmp.exp_full = 0; tmp.exp_data = 32'h77;
        apply(tmp, "post_rst");

        bus.wr_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
